imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader_timeout.sv | 32 +++
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// stream-format constants and the length-byte decode helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_WORDS      = 256;
    localparam int WORD_CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    // A length byte of zero stands for the full 256-word image.
    function automatic logic [WORD_CNT_W-1:0] words_from_len(input logic [7:0] len);
        return (len == 8'd0) ? WORD_CNT_W'(MAX_WORDS) : WORD_CNT_W'(len);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader connects through the master modport, its environment through slave.
interface imem_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/imem_loader_timeout.sv
// Idle-cycle counter: counts enabled cycles since the last clear and flags
// the cycle on which the TIMEOUT-th consecutive idle cycle is under way.
module imem_loader_timeout #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int                CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]     LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && cnt_q != LIMIT) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory,
// one 32-bit word write per four stream bytes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    imem_loader_if.master         bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [WORD_CNT_W-1:0] word_count
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    state_t                  state_q, state_nxt;
    logic [WORD_CNT_W-1:0]   word_count_q;
    logic [WORD_CNT_W-1:0]   n_words_q;
    logic [BYTE_IDX_W-1:0]   byte_idx_q;
    logic [7:0]              xor_q;
    logic [31:0]             asm_q;
    logic [31:0]             wr_data_hold_q;
    logic [31:0]             wr_addr_q;
    logic                    wr_en_q;

    logic active, xfer, start_ok, expired, last_byte, last_word;

    assign active    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
    assign xfer      = bus.byte_valid && active;
    assign start_ok  = start && !active;
    assign last_byte = (byte_idx_q == LAST_IDX);
    assign last_word = (word_count_q == n_words_q - WORD_CNT_W'(1));

    imem_loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (active),
        .clear   (xfer || start_ok),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_nxt;
    end

    // NOTE: next-state is assigned a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN;
            S_LEN: begin
                if (xfer)         state_nxt = S_DATA;
                else if (expired) state_nxt = S_ERR;
            end
            S_DATA: begin
                if (xfer) begin
                    if (last_byte && last_word) state_nxt = S_CHECK;
                end else if (expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_CHECK: begin
                if (xfer)         state_nxt = (bus.byte_data == xor_q) ? S_DONE : S_ERR;
                else if (expired) state_nxt = S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The write is issued the cycle after the fourth byte; asm_q holds the full
    // word during that cycle and is then parked in the hold register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count_q   <= '0;
            n_words_q      <= '0;
            byte_idx_q     <= '0;
            xor_q          <= '0;
            asm_q          <= '0;
            wr_data_hold_q <= '0;
            wr_addr_q      <= '0;
            wr_en_q        <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (wr_en_q) wr_data_hold_q <= asm_q;
            if (start_ok) begin
                word_count_q <= '0;
                n_words_q    <= '0;
                byte_idx_q   <= '0;
                xor_q        <= '0;
                asm_q        <= '0;
            end else if (xfer) begin
                case (state_q)
                    S_LEN: n_words_q <= words_from_len(bus.byte_data);
                    S_DATA: begin
                        asm_q      <= {asm_q[23:0], bus.byte_data};
                        xor_q      <= xor_q ^ bus.byte_data;
                        byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
                        if (last_byte) begin
                            wr_en_q      <= 1'b1;
                            wr_addr_q    <= BASE_ADDR + (32'(word_count_q) << 2);
                            word_count_q <= word_count_q + WORD_CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready = active;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_en_q ? asm_q : wr_data_hold_q;

    assign busy       = active;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are sent
// and popped by a write monitor; status is checked after each load.
module tb_imem_loader;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] BASE    = 32'h0000_0000;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [8:0] word_count;

    imem_loader_if bus ();

    imem_loader #(.BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] words[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write monitor: every wr_en pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                assert (exp_q.size() != 0)
                else begin
                    n_fail++;
                    $error("FAIL unexpected_write: observed write addr 0x%08h data 0x%08h expected none",
                           bus.wr_addr, bus.wr_data);
                end
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, mon_e.addr);
                check("wr_data", bus.wr_data, mon_e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        k = 0;
        while (bus.byte_ready !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        assert (k < 64)
        else begin
            n_fail++;
            $error("FAIL byte_ready_wait: observed no ready for %0d cycles expected ready", k);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    // gap < 0 selects a random idle gap of 0..8 cycles before each byte.
    task automatic do_gap(input int gap);
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 8)) : gap;
        repeat (g) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_load(input bit bad, input int gap, input bit mid_start);
        logic [7:0] x;
        logic [7:0] len;
        x   = 8'h00;
        len = (words.size() == 256) ? 8'd0 : 8'(words.size());
        pulse_start();
        do_gap(gap);
        send_byte(len);
        for (int i = 0; i < words.size(); i++) begin
            logic [31:0] w;
            w = words[i];
            exp_q.push_back('{addr: BASE + 32'(4 * i), data: w});
            for (int b = 0; b < 4; b++) begin
                logic [7:0] v;
                v = w[31 - 8 * b -: 8];
                x = x ^ v;
                if (mid_start && i == 0 && b == 1) pulse_start();
                do_gap(gap);
                send_byte(v);
            end
        end
        do_gap(gap);
        send_byte(bad ? 8'h00 : x);
        repeat (2) @(negedge clk);
        check("done",        done,  {31'd0, !bad});
        check("error",       error, {31'd0, bad});
        check("busy_after",  busy,  0);
        check("word_count",  word_count, words.size());
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic load_fixed_words();
        words.delete();
        words.push_back(32'h2004_2F5B);
        words.push_back(32'h2405_CFC7);
    endtask

    initial begin
        int k;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",       busy, 0);
        check("rst_done",       done, 0);
        check("rst_error",      error, 0);
        check("rst_byte_ready", bus.byte_ready, 0);
        check("rst_wr_en",      bus.wr_en, 0);
        check("rst_word_count", word_count, 0);
        check("rst_wr_addr",    bus.wr_addr, 0);
        check("rst_wr_data",    bus.wr_data, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Normal load; XOR of the eight bytes is 0x79. A start mid-load is ignored.
        load_fixed_words();
        send_load(1'b0, 0, 1'b1);
        check("hold_wr_addr", bus.wr_addr, 32'h0000_0004);
        check("hold_wr_data", bus.wr_data, 32'h2405_CFC7);

        // Bad checksum: writes still happen, load ends in error.
        send_load(1'b1, 0, 1'b0);

        // Random backpressure gaps well under the timeout.
        send_load(1'b0, -1, 1'b0);

        // Gap of TIMEOUT-1 idle cycles: transfer coincides with expiry and wins.
        send_load(1'b0, TIMEOUT - 1, 1'b0);

        // L = 0: full 256-word image ending at 0x3FC.
        words.delete();
        for (int i = 0; i < 256; i++)
            words.push_back({i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3});
        send_load(1'b0, 0, 1'b0);
        check("full_last_addr", bus.wr_addr, 32'h0000_03FC);

        // Stall after three data bytes.
        pulse_start();
        send_byte(8'd2);
        send_byte(8'h20);
        send_byte(8'h04);
        send_byte(8'h2F);
        k = 0;
        while (error !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        assert (k >= TIMEOUT / 2 && k <= TIMEOUT)
        else begin
            n_fail++;
            $error("FAIL timeout_latency: observed %0d cycles expected %0d..%0d", k, TIMEOUT / 2, TIMEOUT);
        end
        check("timeout_error",      error, 1);
        check("timeout_busy",       busy, 0);
        check("timeout_done",       done, 0);
        check("timeout_word_count", word_count, 0);
        check("timeout_ready",      bus.byte_ready, 0);

        // Reset after the first word is written aborts the load.
        load_fixed_words();
        pulse_start();
        send_byte(8'd2);
        exp_q.push_back('{addr: BASE, data: 32'h2004_2F5B});
        send_byte(8'h20);
        send_byte(8'h04);
        send_byte(8'h2F);
        send_byte(8'h5B);
        repeat (3) @(negedge clk);
        send_byte(8'h24);
        send_byte(8'h05);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy",       busy, 0);
        check("mid_rst_error",      error, 0);
        check("mid_rst_done",       done, 0);
        check("mid_rst_wr_en",      bus.wr_en, 0);
        check("mid_rst_word_count", word_count, 0);
        check("mid_rst_wr_addr",    bus.wr_addr, 0);
        check("mid_rst_wr_data",    bus.wr_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hCF;
        repeat (10) @(negedge clk);
        bus.byte_valid = 1'b0;
        check("mid_rst_idle_ready", bus.byte_ready, 0);
        check("mid_rst_no_writes",  exp_q.size(), 0);
        send_load(1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
